instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the fetch address width (matches the program counter width).
REQ-002 Parameter INSTR_W, default 16, SHALL set the instruction word width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 pc_in  input  ADDR_W  SHALL carry the current program counter value.
REQ-006 pc_advance  output  1  SHALL be a one-cycle pulse telling the program counter to step to the next address.
REQ-007 flush  input  1  SHALL, when high for one cycle, discard all buffered and in-flight fetches (asserted together with a PC load).
REQ-008 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-009 imem_addr  output  ADDR_W  SHALL be the instruction-memory read address.
REQ-010 imem_ack  input  1  SHALL mark imem_rdata valid; meaningful only while imem_req=1.
REQ-011 imem_rdata  input  INSTR_W  SHALL be the read data.
REQ-012 instr_valid  output  1  SHALL indicate that instr_out/instr_pc hold the oldest buffered instruction.
REQ-013 instr_out  output  INSTR_W  SHALL be the instruction word presented to decode.
REQ-014 instr_pc  output  ADDR_W  SHALL be the fetch address of instr_out.
REQ-015 instr_ready  input  1  SHALL be the decode-stage accept signal.
REQ-016 buf_count  output  2  SHALL report buffer occupancy (0..2).

Function
REQ-017 Memory side SHALL be a state machine with states IDLE, REQ, DROP.
REQ-018 IDLE: if buf_count<2 and flush=0, next state REQ, imem_addr <= pc_in; otherwise stay IDLE.
REQ-019 REQ/DROP: imem_req=1, imem_addr held stable until imem_ack; at most one request outstanding.
REQ-020 REQ with imem_ack=1 and flush=0: push {imem_addr, imem_rdata} into the buffer, pc_advance=1 that same cycle, next state IDLE.
REQ-021 REQ with flush=1 and imem_ack=0: next state DROP; REQ with flush=1 and imem_ack=1: data discarded, pc_advance=0, next state IDLE.
REQ-022 DROP: on imem_ack, data discarded, pc_advance=0, next state IDLE; further flush pulses while in DROP keep state DROP.
REQ-023 IDLE: imem_req=0 and pc_advance=0.
REQ-024 Buffer: 2-entry FIFO of {pc, instr}, in-order; pop when instr_valid=1 and instr_ready=1.
REQ-025 Push into empty buffer SHALL make instr_valid=1 the following cycle (registered, no bypass); minimum request-to-valid latency = ack cycle + 1.
REQ-026 Simultaneous push and pop SHALL leave buf_count unchanged and preserve order.
REQ-027 Push never occurs with buf_count=2 (guaranteed by REQ-018); pop with buf_count=0 SHALL have no effect.
REQ-028 flush SHALL set buf_count=0 and instr_valid=0 on the next cycle; a pop in the flush cycle is still accepted by decode but the entry is not retained.
REQ-029 instr_out/instr_pc SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-030 No address arithmetic in this block; pc_in wrap (0xFF->0x00) is owned by the program counter.
REQ-031 Peak throughput: one instruction per 2 cycles (IDLE + REQ with immediate ack).

Reset
REQ-032 reset=1 SHALL on the next edge force state IDLE, buf_count=0, imem_req=0, imem_addr=0, pc_advance=0, instr_valid=0, instr_out=0, instr_pc=0.
REQ-033 reset mid-REQ/DROP SHALL abandon the request; a late imem_ack after reset SHALL be ignored (state IDLE).
REQ-034 First request SHALL issue the cycle after the first IDLE cycle following reset release.

Verification
REQ-035 Reset, pc_in=0x00, instr_ready=1, imem_ack one cycle after imem_req with rdata=0xA55A -> imem_addr=0x00, pc_advance pulse in ack cycle, next cycle instr_valid=1, instr_out=0xA55A, instr_pc=0x00.
REQ-036 instr_ready=0, pc_in 0x10,0x11,0x12 via pc_advance -> two entries buffered (buf_count=2), imem_req stays 0; raise instr_ready -> 0x10 then 0x11 delivered in order, fetch of 0x12 resumes.
REQ-037 flush during REQ with imem_ack delayed 3 cycles -> imem_req held high with stable addr through DROP, data discarded, pc_advance=0, instr_valid=0, then IDLE.
REQ-038 flush and imem_ack same cycle with buf_count=1 -> no push, no pc_advance, buf_count=0 and instr_valid=0 next cycle.
REQ-039 reset pulsed during REQ, ack arrives next cycle -> imem_req=0, no push, all outputs at reset values.
REQ-040 pc_in=0xFF fetch -> instr_pc=0xFF; subsequent fetch at pc_in=0x00 delivered with instr_pc=0x00.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage for a small in-order core.
// A three-state memory-side controller issues one read at a time at the
// program counter address. Returned words go into a 2-entry in-order buffer
// that feeds decode. A flush discards buffered words and any read in flight.
// The read in flight is still allowed to complete on the memory bus.

module instruction_fetch #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_advance,
    input  logic               flush,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    output logic [1:0]         buf_count
);

    // IDLE : no read outstanding. We may issue a read next cycle.
    // REQ  : a live read is outstanding. Its data is kept.
    // DROP : a read was flushed while outstanding. It completes on the bus
    //        and its data is thrown away.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    // One buffer slot: the fetch address and the word read from that address.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    state_t      state;
    state_t      state_next;
    logic        issue;      // IDLE has decided to start a read at the next edge
    logic        push;       // a live read returns data this cycle
    logic        pop;        // decode takes the oldest entry this cycle
    logic [1:0]  count_q;
    entry_t      slot_q [2]; // slot_q[0] is always the oldest entry
    entry_t      fetched;

    assign fetched = '{pc: imem_addr, instr: imem_rdata};

    // State register for the memory-side controller.
    always_ff @(posedge clk) begin
        // NOTE: every clocked block uses non-blocking (<=) assignments.
        // All registers then update together from values sampled before the
        // edge, and simulation matches the synthesized flops.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and memory-side strobes.
    always_comb begin
        // NOTE: every signal this block drives gets a default before the
        // case statement. Any path that leaves one unassigned would infer
        // a latch.
        state_next = state;
        imem_req   = 1'b0;
        issue      = 1'b0;
        push       = 1'b0;
        case (state)
            S_IDLE: begin
                // Start a read only when the buffer has room for the result.
                // Do not start one while the PC is being reloaded.
                if (count_q != 2'd2 && !flush) begin
                    issue      = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    // A flush in the ack cycle discards the returning word.
                    push       = !flush;
                    state_next = S_IDLE;
                end else if (flush) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The PC steps exactly when a fetched word is kept.
    assign pc_advance = push && !reset;

    // Read address register. It is captured when a read starts and held
    // until the read is acknowledged.
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_addr <= '0;
        end else if (issue) begin
            imem_addr <= pc_in;
        end
    end

    // Pop is qualified by valid, so a pop of an empty buffer does nothing.
    assign pop = (count_q != 2'd0) && instr_ready;

    // Two-entry in-order buffer. Slot 0 always holds the oldest entry, so
    // the decode outputs come straight from flops with no read mux.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the buffer storage is reset along with its count,
            // because decode must see instr_out and instr_pc at zero out of
            // reset, not just instr_valid low.
            count_q   <= 2'd0;
            slot_q[0] <= '0;
            slot_q[1] <= '0;
        end else if (flush) begin
            // Contents are left as they are. A zero count hides them.
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    // Append behind the current entries. Push only happens
                    // when count is 0 or 1, so bit 0 picks the free slot.
                    slot_q[count_q[0]] <= fetched;
                    count_q            <= count_q + 2'd1;
                end
                2'b01: begin
                    slot_q[0] <= slot_q[1];
                    count_q   <= count_q - 2'd1;
                end
                2'b11: begin
                    // The count stays the same. The new word goes in behind
                    // whatever remains after the pop.
                    if (count_q == 2'd2) begin
                        slot_q[0] <= slot_q[1];
                        slot_q[1] <= fetched;
                    end else begin
                        slot_q[0] <= fetched;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign instr_valid = (count_q != 2'd0);
    assign instr_out   = slot_q[0].instr;
    assign instr_pc    = slot_q[0].pc;
    assign buf_count   = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch.
// The bench plays two roles around the DUT:
//   - the program counter: it steps on pc_advance and loads on flush;
//   - the instruction memory: it answers reads after a chosen delay.
// It keeps a transaction-level model of the fetch stage to predict outputs:
//   - whether a read is outstanding and at which address;
//   - whether that read has been flushed;
//   - the queue of {pc, word} pairs owed to decode.
// Every cycle the DUT outputs are compared against that model.

module tb_instruction_fetch;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } item_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [ADDR_W-1:0]  pc_in;
    logic               pc_advance;
    logic               flush;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;
    logic [1:0]         buf_count;

    instruction_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_advance  (pc_advance),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .buf_count   (buf_count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents.
    logic [INSTR_W-1:0] mem [256];

    // Program counter owned by the bench.
    logic [ADDR_W-1:0] pc_reg;

    // Reference model state.
    item_t             q[$];        // words owed to decode, oldest first
    bit                busy;        // a read is outstanding on the bus
    bit                poisoned;    // that read was flushed; drop its data
    int                busy_cycles; // cycles the outstanding read has waited
    logic [ADDR_W-1:0] exp_addr;    // address the outstanding read must show
    bit                armed;       // first reset edge seen; outputs defined
    bit                just_reset;  // previous edge was a reset edge

    // Stimulus knobs.
    bit                force_reset;
    bit                flush_now;
    bit                flush_on_ack;
    bit                rand_flush;
    bit                late_ack;
    int                ready_mode;  // 0 = stall, 1 = accept, 2 = random
    int                ack_delay;   // <0 = random, otherwise fixed wait cycles
    logic [ADDR_W-1:0] flush_pc;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Runs one clock cycle:
    //   - drives inputs on the falling edge;
    //   - compares outputs against the model;
    //   - advances the model to the state it will hold after the rising edge.
    task automatic cycle();
        logic              rst, fl, ack, rdy, adv, start;
        logic [ADDR_W-1:0] new_pc;
        @(negedge clk);
        rst = force_reset;
        fl  = 1'b0;
        ack = 1'b0;
        case (ready_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        if (!rst) begin
            if (busy) begin
                if (ack_delay < 0) ack = ($urandom_range(0, 2) == 0);
                else               ack = (busy_cycles >= ack_delay);
            end
            if (late_ack) ack = 1'b1;
            fl = flush_now
               || (flush_on_ack && busy && ack && q.size() == 1)
               || (rand_flush && $urandom_range(0, 15) == 0);
        end
        new_pc      = rand_flush ? ADDR_W'($urandom) : flush_pc;
        reset       = rst;
        flush       = fl;
        imem_ack    = ack;
        imem_rdata  = (ack && busy) ? mem[exp_addr] : INSTR_W'($urandom);
        instr_ready = rdy;
        pc_in       = pc_reg;
        adv = busy && ack && !fl && !poisoned;
        #1;
        if (armed) begin
            check("imem_req", imem_req, busy);
            if (busy) check("imem_addr", imem_addr, exp_addr);
            check("pc_advance", pc_advance, adv);
            check("buf_count", buf_count, q.size());
            check("instr_valid", instr_valid, q.size() != 0);
            if (q.size() != 0) begin
                check("instr_out", instr_out, q[0].instr);
                check("instr_pc", instr_pc, q[0].pc);
            end
            if (just_reset) begin
                check("rst_instr_out", instr_out, 0);
                check("rst_instr_pc", instr_pc, 0);
                check("rst_imem_addr", imem_addr, 0);
            end
        end
        // Advance the model to the post-edge state.
        if (rst) begin
            busy       = 0;
            poisoned   = 0;
            q.delete();
            armed      = 1;
            just_reset = 1;
        end else begin
            just_reset = 0;
            start = !busy && q.size() < 2 && !fl;
            if (busy) begin
                if (ack) begin
                    busy = 0;
                end else begin
                    busy_cycles++;
                    if (fl) poisoned = 1;
                end
            end
            if (start) begin
                busy        = 1;
                poisoned    = 0;
                busy_cycles = 0;
                exp_addr    = pc_reg;
            end
            if (fl) begin
                q.delete();
            end else begin
                if (q.size() != 0 && rdy) void'(q.pop_front());
                if (adv) q.push_back(item_t'{pc: exp_addr, instr: mem[exp_addr]});
            end
            if (fl)       pc_reg = new_pc;
            else if (adv) pc_reg = pc_reg + 1'b1;
        end
        @(posedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_busy();
        for (int n = 0; n < 20 && !busy; n++) cycle();
        check("req_timeout", busy, 1);
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        pc_in       = '0;
        for (int i = 0; i < 256; i++) mem[i] = INSTR_W'($urandom);
        mem[0]       = 16'hA55A;
        pc_reg       = 8'h00;
        busy         = 0;
        poisoned     = 0;
        busy_cycles  = 0;
        exp_addr     = '0;
        armed        = 0;
        just_reset   = 0;
        flush_now    = 0;
        flush_on_ack = 0;
        rand_flush   = 0;
        late_ack     = 0;
        flush_pc     = '0;

        // Reset, then a first fetch at 0x00. The ack comes one cycle after
        // the request.
        force_reset = 1;
        run(2);
        force_reset = 0;
        ready_mode  = 1;
        ack_delay   = 1;
        run(6);

        // Stall decode and load PC=0x10. Two words are buffered and reads
        // stop. Then drain in order and let the fetch of 0x12 resume.
        ack_delay  = 0;
        ready_mode = 0;
        flush_pc   = 8'h10;
        flush_now  = 1;
        cycle();
        flush_now  = 0;
        run(12);
        #1;
        check("full_count", buf_count, 2);
        check("full_no_req", imem_req, 0);
        check("full_head_pc", instr_pc, 8'h10);
        ready_mode = 1;
        run(10);

        // Randomized mix of ack delays, decode stalls and flushes.
        ack_delay  = -1;
        ready_mode = 2;
        rand_flush = 1;
        run(400);
        rand_flush = 0;

        // Flush on the first REQ cycle with the ack three cycles later.
        // The request and address must be held through DROP, and the data
        // must be dropped.
        ready_mode = 1;
        ack_delay  = 3;
        wait_busy();
        flush_pc   = 8'h40;
        flush_now  = 1;
        cycle();
        flush_now  = 0;
        run(10);

        // Flush in the same cycle as the ack with one word buffered.
        ready_mode   = 0;
        ack_delay    = 1;
        flush_pc     = 8'h80;
        flush_on_ack = 1;
        run(12);
        flush_on_ack = 0;

        // Reset while a read is outstanding, then a late ack the next cycle.
        ready_mode  = 1;
        ack_delay   = 2;
        wait_busy();
        force_reset = 1;
        cycle();
        force_reset = 0;
        #1;
        check("rst_req", imem_req, 0);
        check("rst_adv", pc_advance, 0);
        check("rst_count", buf_count, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_out", instr_out, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_addr", imem_addr, 0);
        late_ack = 1;
        cycle();
        late_ack = 0;
        run(6);

        // Fetch at 0xFF, then the next fetch at 0x00 after the PC wraps.
        ack_delay  = 0;
        ready_mode = 0;
        flush_pc   = 8'hFF;
        flush_now  = 1;
        cycle();
        flush_now  = 0;
        run(10);
        #1;
        check("wrap_head_pc", instr_pc, 8'hFF);
        check("wrap_count", buf_count, 2);
        ready_mode = 1;
        cycle();
        #1;
        check("wrap_next_pc", instr_pc, 8'h00);
        run(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
